// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// The arbitration policy is selected by DATA_MEM_ARB_RR_EN; see data_mem_arbiter.sv.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEFAULT_MEM_WORDS = 32;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker: returns the id of the port to grant this cycle.
// With rr_en low, A wins every contention; with rr_en high, the port not granted last wins.
module arb_pick2
  import data_mem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  input  logic rr_en,
  output logic winner
);

  always_comb begin
    winner = PORT_A;
    if (a_req && b_req) begin
      winner = (rr_en && (last_grant == PORT_A)) ? PORT_B : PORT_A;
    end else if (b_req) begin
      winner = PORT_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single data memory: one access in flight, gnt at N, rvalid at N+2.
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration; default build uses fixed priority (A wins).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       endereco,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              port_q, port_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rst_q;
  logic              last_grant;
  logic              rr_en;
  logic              winner;
  logic              out_en;
  logic              in_range;

`ifdef DATA_MEM_ARB_RR_EN
  logic last_q, last_d;

  assign rr_en      = 1'b1;
  assign last_grant = last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_B;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (a_gnt || b_gnt) begin
      last_d = winner;
    end
  end
`else
  assign rr_en      = 1'b0;
  assign last_grant = PORT_B;
`endif

  arb_pick2 u_pick (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_grant (last_grant),
    .rr_en      (rr_en),
    .winner     (winner)
  );

  // Outputs stay quiet in the reset cycle and the one following it.
  assign out_en   = !reset && !rst_q;
  assign in_range = (addr_q < MEM_WORDS_W);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    port_d     = port_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_rvalid   = 1'b0;
    b_rvalid   = 1'b0;
    a_rdata    = '0;
    b_rdata    = '0;
    a_err      = 1'b0;
    b_err      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    endereco   = '0;
    write_data = '0;

    case (state_q)
      IDLE: begin
        if ((a_req || b_req) && out_en) begin
          state_d = ACCESS;
          port_d  = winner;
          if (winner == PORT_A) begin
            a_gnt   = 1'b1;
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
          end else begin
            b_gnt   = 1'b1;
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (out_en) begin
          endereco   = addr_q;
          write_data = wdata_q;
          mem_read   = in_range && !we_q;
          mem_write  = in_range && we_q;
        end
        rdata_d = (in_range && !we_q) ? read_data : '0;
        err_d   = !in_range;
      end
      RESP: begin
        state_d = IDLE;
        if (out_en) begin
          if (port_q == PORT_A) begin
            a_rvalid = 1'b1;
            a_rdata  = rdata_q;
            a_err    = err_q;
          end else begin
            b_rvalid = 1'b1;
            b_rdata  = rdata_q;
            b_err    = err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rst_q   <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= PORT_A;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      port_q  <= port_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: drivers feed per-port command queues, a monitor checks responses.
// Expected grant order follows DATA_MEM_ARB_RR_EN when defined, fixed priority otherwise.
module tb_data_mem_arbiter;

  localparam int DW = 32;
  localparam int MW = 32;

  typedef struct packed {
    logic          we;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [31:0]   a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [31:0]   b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_read, mem_write;
  logic [31:0]   endereco;
  logic [DW-1:0] write_data, read_data;

  logic [DW-1:0] mem [0:MW-1];
  cmd_t a_cmds[$];
  cmd_t b_cmds[$];
  exp_t exp_q[$];
  logic gl_port[$];
  int   gl_cyc[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_prev = 1'b0;
  int a_gnt_cyc = -100, b_gnt_cyc = -100, mr_cyc = -100, mw_cyc = -100;
  int a_gnt_cnt = 0, mr_cnt = 0, mw_cnt = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_read(mem_read), .mem_write(mem_write), .endereco(endereco),
    .write_data(write_data), .read_data(read_data)
  );

  assign read_data = (mem_read && endereco < MW) ? mem[endereco[4:0]] : '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= reset;
  end

  // Data memory model: preset contents 0x1000+addr, written on the clock edge.
  initial begin
    for (int i = 0; i < MW; i++) mem[i] = 32'h1000 + i;
    forever begin
      @(posedge clk);
      if (mem_write && endereco < MW) mem[endereco[4:0]] = write_data;
    end
  end

  initial begin : drv_a
    logic g;
    cmd_t c;
    forever begin
      @(negedge clk);
      g = a_gnt;
      @(posedge clk);
      #1;
      if (g) a_req = 1'b0;
      if (!a_req && a_cmds.size() > 0) begin
        c = a_cmds.pop_front();
        a_we = c.we; a_addr = c.addr; a_wdata = c.wdata; a_req = 1'b1;
      end
    end
  end

  initial begin : drv_b
    logic g;
    cmd_t c;
    forever begin
      @(negedge clk);
      g = b_gnt;
      @(posedge clk);
      #1;
      if (g) b_req = 1'b0;
      if (!b_req && b_cmds.size() > 0) begin
        c = b_cmds.pop_front();
        b_we = c.we; b_addr = c.addr; b_wdata = c.wdata; b_req = 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic p;
    logic [DW-1:0] rd;
    logic er;
    int gc;
    forever begin
      @(negedge clk);
      if (reset || rst_prev) begin
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_read, mem_write} != 8'b0 ||
            a_rdata != '0 || b_rdata != '0 || endereco != '0 || write_data != '0) begin
          failures++;
          $display("FAIL reset_outputs cyc=%0d gnt=%b%b rvalid=%b%b rd=%b wr=%b addr=%h required all zero",
                   cyc, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write, endereco);
        end
      end
      if (a_gnt || b_gnt) begin
        checks++;
        if (a_gnt && b_gnt) begin
          failures++;
          $display("FAIL single_gnt cyc=%0d both gnt high, required one", cyc);
        end
        p = b_gnt;
        gl_port.push_back(p);
        gl_cyc.push_back(cyc);
        if (a_gnt) begin a_gnt_cyc = cyc; a_gnt_cnt++; end
        if (b_gnt) b_gnt_cyc = cyc;
      end
      if (mem_read) begin mr_cyc = cyc; mr_cnt++; end
      if (mem_write) begin mw_cyc = cyc; mw_cnt++; end
      if (a_rvalid || b_rvalid) begin
        checks++;
        if (a_rvalid && b_rvalid) begin
          failures++;
          $display("FAIL single_rvalid cyc=%0d both rvalid high, required one", cyc);
        end
        p  = b_rvalid;
        rd = p ? b_rdata : a_rdata;
        er = p ? b_err : a_err;
        gc = p ? b_gnt_cyc : a_gnt_cyc;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid cyc=%0d port=%0d, required no response", cyc, p);
        end else begin
          e = exp_q.pop_front();
          checks += 5;
          if (p != e.port) begin
            failures++;
            $display("FAIL rvalid_port cyc=%0d got=%0d required=%0d", cyc, p, e.port);
          end
          if (rd != e.rdata) begin
            failures++;
            $display("FAIL rdata cyc=%0d port=%0d got=%h required=%h", cyc, p, rd, e.rdata);
          end
          if (er != e.err) begin
            failures++;
            $display("FAIL err cyc=%0d port=%0d got=%0d required=%0d", cyc, p, er, e.err);
          end
          if (cyc != gc + 2) begin
            failures++;
            $display("FAIL latency port=%0d rvalid_cyc=%0d gnt_cyc=%0d required gnt+2", p, cyc, gc);
          end
          if (e.err) begin
            if (mr_cyc >= gc || mw_cyc >= gc) begin
              failures++;
              $display("FAIL oor_strobe port=%0d last_rd=%0d last_wr=%0d gnt=%0d required no strobe",
                       p, mr_cyc, mw_cyc, gc);
            end
          end else if ((e.we ? mw_cyc : mr_cyc) != gc + 1) begin
            failures++;
            $display("FAIL strobe_cycle port=%0d we=%0d strobe_cyc=%0d required=%0d",
                     p, e.we, e.we ? mw_cyc : mr_cyc, gc + 1);
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic port, input logic we, input logic [31:0] addr,
                          input logic [DW-1:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    if (port) b_cmds.push_back(c);
    else a_cmds.push_back(c);
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [DW-1:0] rdata,
                          input logic err);
    exp_t e;
    e.port = port; e.we = we; e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || a_cmds.size() != 0 || b_cmds.size() != 0 || a_req || b_req)
           && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout pending_exp=%0d required 0 within %0d cycles", name, exp_q.size(), budget);
      exp_q.delete(); a_cmds.delete(); b_cmds.delete();
      a_req = 1'b0; b_req = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Bit i of ports is the required port of the i-th grant since log index s; grants 3 cycles apart.
  task automatic check_gnts(input int s, input logic [7:0] ports, input int n, input string name);
    checks++;
    if (gl_port.size() - s != n) begin
      failures++;
      $display("FAIL %s_gnt_count got=%0d required=%0d", name, gl_port.size() - s, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (gl_port[s + i] != ports[i]) begin
          failures++;
          $display("FAIL %s_gnt_order idx=%0d got=%0d required=%0d", name, i, gl_port[s + i], ports[i]);
        end
        if (i > 0) begin
          checks++;
          if (gl_cyc[s + i] - gl_cyc[s + i - 1] != 3) begin
            failures++;
            $display("FAIL %s_gnt_spacing idx=%0d got=%0d required=3", name, i,
                     gl_cyc[s + i] - gl_cyc[s + i - 1]);
          end
        end
      end
    end
  endtask

  initial begin : main
    int s, mr0, mw0, g0, n;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    // Write then read back through port A.
    push_cmd(1'b0, 1'b1, 32'd5, 32'h0000_CAFE); push_exp(1'b0, 1'b1, '0, 1'b0);
    push_cmd(1'b0, 1'b0, 32'd5, '0);            push_exp(1'b0, 1'b0, 32'h0000_CAFE, 1'b0);
    drain(40, "wr_rd");
    $display("txn wr_rd done cyc=%0d", cyc);

    // Out-of-range read on port B.
    mr0 = mr_cnt; mw0 = mw_cnt;
    push_cmd(1'b1, 1'b0, 32'd32, '0); push_exp(1'b1, 1'b0, '0, 1'b1);
    drain(40, "oor");
    checks++;
    if (mr_cnt != mr0 || mw_cnt != mw0) begin
      failures++;
      $display("FAIL oor_strobes rd=%0d wr=%0d required=0/0", mr_cnt - mr0, mw_cnt - mw0);
    end
    $display("txn oor done cyc=%0d", cyc);

    // Contention: A streams four reads, B one read.
    s = gl_port.size();
    push_cmd(1'b0, 1'b0, 32'd0, '0); push_cmd(1'b0, 1'b0, 32'd1, '0);
    push_cmd(1'b0, 1'b0, 32'd2, '0); push_cmd(1'b0, 1'b0, 32'd4, '0);
    push_cmd(1'b1, 1'b0, 32'd16, '0);
`ifdef DATA_MEM_ARB_RR_EN
    push_exp(1'b0, 1'b0, 32'h1000, 1'b0); push_exp(1'b1, 1'b0, 32'h1010, 1'b0);
    push_exp(1'b0, 1'b0, 32'h1001, 1'b0); push_exp(1'b0, 1'b0, 32'h1002, 1'b0);
    push_exp(1'b0, 1'b0, 32'h1004, 1'b0);
    drain(100, "contend");
    check_gnts(s, 8'b0000_0010, 5, "contend");
`else
    push_exp(1'b0, 1'b0, 32'h1000, 1'b0); push_exp(1'b0, 1'b0, 32'h1001, 1'b0);
    push_exp(1'b0, 1'b0, 32'h1002, 1'b0); push_exp(1'b0, 1'b0, 32'h1004, 1'b0);
    push_exp(1'b1, 1'b0, 32'h1010, 1'b0);
    drain(100, "contend");
    check_gnts(s, 8'b0001_0000, 5, "contend");
`endif
    $display("txn contend done cyc=%0d", cyc);

    // Eight back-to-back requests, both ports always pending.
    s = gl_port.size();
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, 1'b0, 32'd6 + 32'(i), '0);
      push_cmd(1'b1, 1'b0, 32'd20 + 32'(i), '0);
    end
`ifdef DATA_MEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b1, 1'b0, 32'h1014 + 32'(i), 1'b0);
      push_exp(1'b0, 1'b0, 32'h1006 + 32'(i), 1'b0);
    end
    drain(100, "alt");
    check_gnts(s, 8'b0101_0101, 8, "alt");
`else
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 32'h1006 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b0, 32'h1014 + 32'(i), 1'b0);
    drain(100, "alt");
    check_gnts(s, 8'b1111_0000, 8, "alt");
`endif
    $display("txn alt done cyc=%0d", cyc);

    // Reset during ACCESS of a write: no write, no response.
    mw0 = mw_cnt; g0 = a_gnt_cnt; n = 0;
    push_cmd(1'b0, 1'b1, 32'd3, 32'h55);
    while (a_gnt_cnt == g0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (a_gnt_cnt == g0) begin
      failures++;
      $display("FAIL rst_wr_gnt got no a_gnt within 20 cycles, required one");
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (mw_cnt != mw0) begin
      failures++;
      $display("FAIL rst_no_write got=%0d writes required=0", mw_cnt - mw0);
    end
    push_cmd(1'b0, 1'b0, 32'd3, '0); push_exp(1'b0, 1'b0, 32'h1003, 1'b0);
    drain(40, "rst_rd");
    $display("txn rst_rd done cyc=%0d", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
